// File: rtl/bicubic_tap_buffer.sv
// bicubic_tap_buffer: NUM_TAPS-bank interleaved pixel line buffer, NUM_TAPS adjacent taps per read,
// fixed 3-cycle read latency. Define EDGE_CLAMP_EN for edge replication; otherwise tap addresses wrap.
module bicubic_tap_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_TAPS   = 4,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [ADDR_WIDTH:0]            line_len,
    input  logic                           rd_req,
    input  logic [ADDR_WIDTH:0]            rd_base,
    output logic                           rd_valid,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] rd_data,
    output logic                           rd_clamped
);
    localparam int TAP_BITS  = $clog2(NUM_TAPS);
    localparam int WORD_BITS = ADDR_WIDTH - TAP_BITS;
    localparam int DEPTH     = (2**ADDR_WIDTH) / NUM_TAPS;

    logic                          wr_vld_q, wr_vld_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]         wr_data_q, wr_data_d;

    logic                          s1_vld_q, s1_vld_d;
    logic [WORD_BITS-1:0]          s1_word_q [NUM_TAPS];
    logic [WORD_BITS-1:0]          s1_word_d [NUM_TAPS];
    logic [TAP_BITS-1:0]           s1_bank_q [NUM_TAPS];
    logic [TAP_BITS-1:0]           s1_bank_d [NUM_TAPS];
    logic                          s1_clamp_q, s1_clamp_d;

    logic                          s2_vld_q, s2_vld_d;
    logic [TAP_BITS-1:0]           s2_bank_q [NUM_TAPS];
    logic [TAP_BITS-1:0]           s2_bank_d [NUM_TAPS];
    logic                          s2_clamp_q, s2_clamp_d;

    logic                          rd_valid_q, rd_valid_d;
    logic [NUM_TAPS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                          rd_clamped_q, rd_clamped_d;

    logic [DATA_WIDTH-1:0]         mem [NUM_TAPS][DEPTH];
    logic [DATA_WIDTH-1:0]         bank_rd_q [NUM_TAPS];

    logic [TAP_BITS-1:0]           start_low;
    logic [WORD_BITS-1:0]          start_word;

    always_comb begin
        wr_vld_d  = wr_en;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
    end

`ifdef EDGE_CLAMP_EN
    logic signed [ADDR_WIDTH+1:0] base_s, start_s, lim_s, last_s, tap_s, k_s;

    // Window start is clamped into the line so every clamped tap still falls in one bank each.
    always_comb begin
        base_s     = {rd_base[ADDR_WIDTH], rd_base};
        lim_s      = $signed({1'b0, line_len}) - (ADDR_WIDTH+2)'(NUM_TAPS);
        last_s     = $signed({1'b0, line_len}) - (ADDR_WIDTH+2)'(1);
        start_s    = base_s[ADDR_WIDTH+1] ? '0 : base_s;
        if (start_s > lim_s) start_s = lim_s;
        s1_clamp_d = 1'b0;
        k_s        = '0;
        tap_s      = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            k_s   = (ADDR_WIDTH+2)'(k);
            tap_s = base_s + k_s;
            if (tap_s[ADDR_WIDTH+1]) begin
                tap_s      = '0;
                s1_clamp_d = 1'b1;
            end else if (tap_s > last_s) begin
                tap_s      = last_s;
                s1_clamp_d = 1'b1;
            end
            s1_bank_d[k] = tap_s[TAP_BITS-1:0];
        end
        start_low  = start_s[TAP_BITS-1:0];
        start_word = start_s[ADDR_WIDTH-1:TAP_BITS];
    end
`else
    logic unused_wrap;
    assign unused_wrap = ^{line_len, rd_base[ADDR_WIDTH]};

    always_comb begin
        start_low  = rd_base[TAP_BITS-1:0];
        start_word = rd_base[ADDR_WIDTH-1:TAP_BITS];
        s1_clamp_d = 1'b0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            s1_bank_d[k] = start_low + TAP_BITS'(k);
        end
    end
`endif

    // Banks below the start offset hold the window pixel from the following word.
    always_comb begin
        s1_vld_d = rd_req;
        for (int unsigned b = 0; b < NUM_TAPS; b++) begin
            s1_word_d[b] = start_word + WORD_BITS'(TAP_BITS'(b) < start_low);
        end
    end

    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_bank_d  = s1_bank_q;
        s2_clamp_d = s1_clamp_q;
    end

    always_comb begin
        rd_valid_d   = s2_vld_q;
        rd_clamped_d = rd_clamped_q;
        rd_data_d    = rd_data_q;
        if (s2_vld_q) begin
            rd_clamped_d = s2_clamp_q;
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = bank_rd_q[s2_bank_q[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            s1_vld_q     <= 1'b0;
            s1_word_q    <= '{default: '0};
            s1_bank_q    <= '{default: '0};
            s1_clamp_q   <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_bank_q    <= '{default: '0};
            s2_clamp_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_clamped_q <= 1'b0;
        end else begin
            wr_vld_q     <= wr_vld_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            s1_vld_q     <= s1_vld_d;
            s1_word_q    <= s1_word_d;
            s1_bank_q    <= s1_bank_d;
            s1_clamp_q   <= s1_clamp_d;
            s2_vld_q     <= s2_vld_d;
            s2_bank_q    <= s2_bank_d;
            s2_clamp_q   <= s2_clamp_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_clamped_q <= rd_clamped_d;
        end
    end

    // Read-first banks: a write and a read on the same edge return the old word.
    always_ff @(posedge clk) begin
        if (wr_vld_q) begin
            mem[wr_addr_q[TAP_BITS-1:0]][wr_addr_q[ADDR_WIDTH-1:TAP_BITS]] <= wr_data_q;
        end
        if (s1_vld_q) begin
            for (int unsigned b = 0; b < NUM_TAPS; b++) begin
                bank_rd_q[b] <= mem[b][s1_word_q[b]];
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_clamped = rd_clamped_q;

endmodule
